// File: rtl/systolic_os_stream.sv
// Output-stationary ROWS x COLS systolic MAC array. Streams unskewed A/B beats in and C rows out; the first row is valid ROWS+COLS cycles after the last accepted beat.
// in_ready is high only in LOAD; out_data/out_row hold while out_ready is low. Define SYSTOLIC_OS_RELU_EN to clamp negative outputs to 0.
module systolic_os_stream #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int K_MAX      = 64,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(K_MAX)+1
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    in_a,
  input  logic [COLS*DATA_WIDTH-1:0]    in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic [COLS*ACC_WIDTH-1:0]     out_data,
  output logic                          done
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(ROWS+COLS);
  localparam int PW = 2*DATA_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS+COLS-1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [KW-1:0]            beat_cnt_q, beat_cnt_d;
  logic [KW-1:0]            k_eff_q, k_eff_d;
  logic [FW-1:0]            flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]            out_row_q, out_row_d;
  logic [COLS*ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                     busy_q, busy_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     done_q, done_d;
  logic                     clr_acc;
  logic                     accept;

  logic signed [DW-1:0]     a_lane [ROWS];
  logic                     a_tok  [ROWS];
  logic signed [DW-1:0]     b_lane [COLS];

  // Operands handed PE-to-PE; the last column/row have no consumer so are not exported.
  logic [ROWS*(COLS-1)*DW-1:0]    a_flat;
  logic [ROWS*(COLS-1)-1:0]       v_flat;
  logic [(ROWS-1)*COLS*DW-1:0]    b_flat;
  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_flat;

  assign accept = in_valid && in_ready_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [DW-1:0] a_src;
    assign a_src = accept ? in_a[r*DW +: DW] : '0;
    if (r == 0) begin : g_direct
      assign a_lane[r] = a_src;
      assign a_tok[r]  = accept;
    end else begin : g_delay
      logic signed [DW-1:0] dly_d [r];
      logic signed [DW-1:0] dly_q [r];
      logic [r-1:0]         tok_d, tok_q;
      always_comb begin
        dly_d[0] = a_src;
        tok_d[0] = accept;
        for (int j = 1; j < r; j++) begin
          dly_d[j] = dly_q[j-1];
          tok_d[j] = tok_q[j-1];
        end
      end
      always_ff @(posedge clk) begin
        if (!srstn) begin
          dly_q <= '{default: '0};
          tok_q <= '0;
        end else begin
          dly_q <= dly_d;
          tok_q <= tok_d;
        end
      end
      assign a_lane[r] = dly_q[r-1];
      assign a_tok[r]  = tok_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic signed [DW-1:0] b_src;
    assign b_src = accept ? in_b[c*DW +: DW] : '0;
    if (c == 0) begin : g_direct
      assign b_lane[c] = b_src;
    end else begin : g_delay
      logic signed [DW-1:0] dly_d [c];
      logic signed [DW-1:0] dly_q [c];
      always_comb begin
        dly_d[0] = b_src;
        for (int j = 1; j < c; j++) dly_d[j] = dly_q[j-1];
      end
      always_ff @(posedge clk) begin
        if (!srstn) dly_q <= '{default: '0};
        else        dly_q <= dly_d;
      end
      assign b_lane[c] = dly_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DW-1:0]        a_d, a_q, b_d, b_q;
      logic                        v_d, v_q;
      logic signed [PW-1:0]        prod;
      logic signed [ACC_WIDTH-1:0] acc_d, acc_q;

      if (c == 0) begin : g_a_edge
        assign a_d = a_lane[r];
        assign v_d = a_tok[r];
      end else begin : g_a_int
        assign a_d = a_flat[(r*(COLS-1)+c-1)*DW +: DW];
        assign v_d = v_flat[r*(COLS-1)+c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_d = b_lane[c];
      end else begin : g_b_int
        assign b_d = b_flat[((r-1)*COLS+c)*DW +: DW];
      end

      // A PE without a valid token holds, so input bubbles never corrupt the sum.
      always_comb begin
        prod  = PW'(a_q) * PW'(b_q);
        acc_d = acc_q;
        if (clr_acc)  acc_d = '0;
        else if (v_q) acc_d = acc_q + ACC_WIDTH'(prod);
      end

      always_ff @(posedge clk) begin
        if (!srstn) begin
          a_q   <= '0;
          b_q   <= '0;
          v_q   <= 1'b0;
          acc_q <= '0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          v_q   <= v_d;
          acc_q <= acc_d;
        end
      end

      if (c < COLS-1) begin : g_a_out
        assign a_flat[(r*(COLS-1)+c)*DW +: DW] = a_q;
        assign v_flat[r*(COLS-1)+c]            = v_q;
      end
      if (r < ROWS-1) begin : g_b_out
        assign b_flat[(r*COLS+c)*DW +: DW] = b_q;
      end
      assign acc_flat[(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH] = acc_q;
    end
  end

  // Row to load into out_data on the next update: row 0 on entry to DRAIN, else the next row.
  logic [RW-1:0]             sel_row;
  logic [ACC_WIDTH-1:0]      elem;
  logic [COLS*ACC_WIDTH-1:0] row_vec;

  always_comb begin
    sel_row = '0;
    if (state_q == DRAIN && out_row_q != RW'(ROWS-1)) sel_row = out_row_q + 1'b1;
    row_vec = '0;
    elem    = '0;
    for (int c = 0; c < COLS; c++) begin
      elem = acc_flat[(int'(sel_row)*COLS + c)*ACC_WIDTH +: ACC_WIDTH];
`ifdef SYSTOLIC_OS_RELU_EN
      if (elem[ACC_WIDTH-1]) elem = '0;
`endif
      row_vec[c*ACC_WIDTH +: ACC_WIDTH] = elem;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    k_eff_d     = k_eff_q;
    flush_cnt_d = flush_cnt_q;
    out_row_d   = out_row_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    clr_acc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && k_len != '0) begin
          state_d    = LOAD;
          k_eff_d    = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
          beat_cnt_d = '0;
          clr_acc    = 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          if (beat_cnt_q == k_eff_q - 1'b1) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d    = DRAIN;
          out_row_d  = '0;
          out_data_d = row_vec;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_row_q == RW'(ROWS-1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            out_row_d  = out_row_q + 1'b1;
            out_data_d = row_vec;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      k_eff_q     <= '0;
      flush_cnt_q <= '0;
      out_row_q   <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      k_eff_q     <= k_eff_d;
      flush_cnt_q <= flush_cnt_d;
      out_row_q   <= out_row_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_os_stream.sv
// Bench for systolic_os_stream (4x4, K_MAX=16): reference matrix product from the driven beats.
module tb_systolic_os_stream;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DW    = 8;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX+1);
  localparam int ACC_W = 2*DW + $clog2(K_MAX) + 1;

  logic                   clk = 1'b0;
  logic                   srstn, start, in_valid, out_ready;
  logic [KW-1:0]          k_len;
  logic [ROWS*DW-1:0]     in_a;
  logic [COLS*DW-1:0]     in_b;
  logic                   busy, in_ready, out_valid, done;
  logic [$clog2(ROWS)-1:0] out_row;
  logic [COLS*ACC_W-1:0]  out_data;

  systolic_os_stream #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .K_MAX(K_MAX)) dut (
    .clk(clk), .srstn(srstn), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .done(done));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int ma [24][ROWS];
  int mb [24][COLS];
  longint exp_c [ROWS][COLS];

  // monitor / scoreboard state
  bit job_on = 0, job_done = 0, done_due = 0, drop_due = 0, prev_ov = 0, prev_stall = 0;
  int exp_keff = 0, acc_cnt = 0, rows_seen = 0, done_cnt = 0, last_acc_edge = 0;
  logic [$clog2(ROWS)-1:0] prev_row;
  logic [COLS*ACC_W-1:0]  prev_data;

  // out_ready / late-start driver state
  int or_mode = 0, hold_cnt = 0;
  bit start_on_last = 0, pulsed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [COLS*ACC_W-1:0] act,
                         input logic [COLS*ACC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [COLS*ACC_W-1:0] exp_row_vec(input int r);
    logic [COLS*ACC_W-1:0] res;
    longint v;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      v = exp_c[r][c];
`ifdef SYSTOLIC_OS_RELU_EN
      if (v < 0) v = 0;
`endif
      res[c*ACC_W +: ACC_W] = v[ACC_W-1:0];
    end
    return res;
  endfunction

  function automatic logic [ROWS*DW-1:0] pack_a(input int k);
    logic [ROWS*DW-1:0] v;
    int e;
    for (int r = 0; r < ROWS; r++) begin
      e = ma[k][r];
      v[r*DW +: DW] = e[DW-1:0];
    end
    return v;
  endfunction

  function automatic logic [COLS*DW-1:0] pack_b(input int k);
    logic [COLS*DW-1:0] v;
    int e;
    for (int c = 0; c < COLS; c++) begin
      e = mb[k][c];
      v[c*DW +: DW] = e[DW-1:0];
    end
    return v;
  endfunction

  // Single compare process: every cycle, outputs against the reference.
  always @(negedge clk) begin
    if (!srstn) begin
      job_on = 0; acc_cnt = 0; rows_seen = 0; done_due = 0;
      drop_due = 0; prev_ov = 0; prev_stall = 0;
    end else begin
      if (drop_due) begin
        chk("in_ready_drop", in_ready, 0);
        drop_due = 0;
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        last_acc_edge = cyc + 1;
        if (acc_cnt == exp_keff) drop_due = 1;
        if (acc_cnt > exp_keff) chk("excess_accept", acc_cnt, exp_keff);
      end
      chk("done", done, done_due);
      done_due = 0;
      if (done) begin
        job_done = 1; job_on = 0; done_cnt++;
      end
      if (out_valid) begin
        if (!job_on || rows_seen >= ROWS) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          if (!prev_ov) begin
            chk("first_valid_latency", cyc, last_acc_edge + ROWS + COLS);
            chk("beats_before_drain", acc_cnt, exp_keff);
          end
          if (prev_stall) begin
            chk("stall_row", out_row, prev_row);
            chk_vec("stall_data", out_data, prev_data);
          end
          chk("out_row", out_row, rows_seen);
          chk_vec("out_data", out_data, exp_row_vec(rows_seen));
          if (out_ready) begin
            rows_seen++;
            if (rows_seen == ROWS) done_due = 1;
          end
        end
      end
      prev_ov = out_valid; prev_stall = out_valid && !out_ready;
      prev_row = out_row;  prev_data = out_data;
    end
  end

  // out_ready pattern; optionally raises start in the cycle of the last-row handshake.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (pulsed) begin start = 0; pulsed = 0; end
      case (or_mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: if (out_valid && out_row == 1 && hold_cnt < 5) begin
             out_ready = 0; hold_cnt++;
           end else out_ready = 1;
        default: out_ready = 1;
      endcase
      if (start_on_last && out_valid && out_ready && out_row == ROWS-1) begin
        start = 1; pulsed = 1;
      end
    end
  end

  task automatic run_job(input int klen, input int gapmode, input int ormode,
                         input bit mid_start, input bit last_start);
    int keff, i, p, budget, d0;
    bit v;
    logic [5:0] vpat;
    vpat = 6'b101001;
    keff = (klen > K_MAX) ? K_MAX : klen;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_c[r][c] = 0;
        for (int k = 0; k < keff; k++) exp_c[r][c] += longint'(ma[k][r]) * longint'(mb[k][c]);
      end
    @(posedge clk); #1;
    or_mode = ormode; hold_cnt = 0; start_on_last = last_start;
    exp_keff = keff; acc_cnt = 0; rows_seen = 0; job_done = 0; job_on = 1; d0 = done_cnt;
    start = 1; k_len = KW'(klen);
    @(posedge clk); #1;
    start = 0;
    i = 0; p = 0; budget = 0;
    while (i < klen && budget < 3*klen + 40) begin
      if (gapmode == 0)      v = 1;
      else if (gapmode == 1) v = (p < 6) ? vpat[p] : 1'b1;
      else                   v = ($urandom_range(0, 2) != 0);
      in_valid = v; in_a = pack_a(i); in_b = pack_b(i);
      if (mid_start && p == 1) begin start = 1; k_len = KW'(7); end
      @(negedge clk);
      if (v && in_ready) i++;
      @(posedge clk); #1;
      if (mid_start && p == 1) begin start = 0; k_len = KW'(klen); end
      p++; budget++;
    end
    in_valid = 0;
    budget = 0;
    while (!job_done && budget < 300) begin
      @(negedge clk); budget++;
    end
    chk("job_completed", job_done, 1);
    chk("accepted_beats", acc_cnt, keff);
    chk("done_pulses", done_cnt - d0, 1);
    @(posedge clk); #1;
    or_mode = 0; start_on_last = 0;
  endtask

  initial begin
    logic [COLS*ACC_W-1:0] rv;
    int n, b;
    srstn = 0; start = 0; k_len = '0; in_valid = 0; in_a = '0; in_b = '0; out_ready = 1;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out_row", out_row, 0);
    chk_vec("rst_out_data", out_data, '0);
    @(posedge clk); #1; srstn = 1;

    // k_len == 0 is ignored
    @(posedge clk); #1; start = 1; k_len = '0;
    @(posedge clk); #1; start = 0;
    repeat (3) begin @(negedge clk); chk("k0_busy", busy, 0); end

    // identity
    for (int k = 0; k < 24; k++) begin
      for (int r = 0; r < ROWS; r++) ma[k][r] = (r == k) ? 1 : 0;
      for (int c = 0; c < COLS; c++) mb[k][c] = 4*k + c - 8;
    end
    run_job(4, 0, 0, 0, 0);
    chk("pin_id_00", exp_c[0][0], -8);
    chk("pin_id_01", exp_c[0][1], -7);
    chk("pin_id_02", exp_c[0][2], -6);
    chk("pin_id_03", exp_c[0][3], -5);
    chk("pin_id_33", exp_c[3][3], 7);

    // signed extremes
    for (int k = 0; k < 24; k++) begin
      for (int r = 0; r < ROWS; r++) ma[k][r] = -128;
      for (int c = 0; c < COLS; c++) mb[k][c] = -128;
    end
    run_job(16, 0, 0, 0, 0);
    chk("pin_neg_neg", exp_c[2][1], 262144);
    for (int k = 0; k < 24; k++) for (int c = 0; c < COLS; c++) mb[k][c] = 127;
    run_job(16, 0, 2, 0, 0);
    rv = exp_row_vec(1);
`ifdef SYSTOLIC_OS_RELU_EN
    chk("pin_neg_pos", longint'($signed(rv[ACC_W-1:0])), 0);
`else
    chk("pin_neg_pos", longint'($signed(rv[ACC_W-1:0])), -260096);
`endif
    chk("backpressure_hold", hold_cnt, 5);

    // input bubbles 1,0,0,1,0,1
    for (int k = 0; k < 24; k++) begin
      for (int r = 0; r < ROWS; r++) ma[k][r] = 1;
      for (int c = 0; c < COLS; c++) mb[k][c] = 2;
    end
    run_job(3, 1, 0, 0, 0);
    chk("pin_bubbles", exp_c[3][0], 6);

    // k_len above K_MAX, start during LOAD and on the final handshake
    for (int k = 0; k < 24; k++) begin
      for (int r = 0; r < ROWS; r++) ma[k][r] = k + r - 5;
      for (int c = 0; c < COLS; c++) mb[k][c] = 3 - k + c;
    end
    run_job(20, 0, 0, 1, 1);
    repeat (3) begin @(negedge clk); chk("late_start_ignored", busy, 0); end

    // reset during LOAD
    for (int k = 0; k < 24; k++) begin
      for (int r = 0; r < ROWS; r++) ma[k][r] = 1;
      for (int c = 0; c < COLS; c++) mb[k][c] = 1;
    end
    @(posedge clk); #1;
    exp_keff = 4; acc_cnt = 0; job_on = 1; start = 1; k_len = KW'(4);
    @(posedge clk); #1;
    start = 0; n = 0; b = 0;
    while (n < 2 && b < 20) begin
      in_valid = 1; in_a = pack_a(n); in_b = pack_b(n);
      @(negedge clk);
      if (in_ready) n++;
      @(posedge clk); #1; b++;
    end
    in_valid = 0;
    chk("mid_load_accepts", acc_cnt, 2);
    srstn = 0;
    @(posedge clk); #1; srstn = 1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    run_job(2, 0, 0, 0, 0);
    chk("pin_after_reset", exp_c[1][2], 2);

    // randomized jobs
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < 24; k++) begin
        for (int r = 0; r < ROWS; r++) ma[k][r] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < COLS; c++) mb[k][c] = int'($urandom_range(0, 255)) - 128;
      end
      run_job(int'($urandom_range(1, 18)), 2, 1, 0, 0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
